// File: rtl/polar_pkg.sv
// Shared definitions for the SC polar decoder partial-sum control path:
// datapath state codes, controller FSM states and the bit-index width.
package polar_pkg;

    localparam int PS_STATE_WIDTH    = 10;
    localparam int ID_COUNTER_WIDTH  = 10;
    localparam int PS_MAX_CAL_PASSES = 512;

    localparam logic [PS_STATE_WIDTH-1:0] PS_IDLE    = 10'd0;
    localparam logic [PS_STATE_WIDTH-1:0] PS_NEW_BIT = 10'd16;
    localparam logic [PS_STATE_WIDTH-1:0] PS_READ    = 10'd32;
    localparam logic [PS_STATE_WIDTH-1:0] PS_CAL     = 10'd64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEW,
        S_READ,
        S_CAL,
        S_DONE
    } ps_ctrl_state_t;

endpackage

// File: rtl/ps_pass_watchdog.sv
// Counts CAL_AND_STORE passes for the bit in flight and raises a sticky
// error when the datapath fails to report finish within the pass budget.
module ps_pass_watchdog #(
    parameter int MAX_PASSES = 512,
    parameter int CNT_W      = $clog2(MAX_PASSES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_cnt_i,
    input  logic cal_active_i,
    input  logic cal_fin_i,
    input  logic clear_err_i,
    output logic expire_o,
    output logic error_o
);

    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(MAX_PASSES - 1);

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic             error_q, error_d;

    // The pass that would reach the budget without finish is the one that aborts.
    always_comb begin
        expire_o = cal_active_i && !cal_fin_i && (pass_cnt_q == LAST_PASS);
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (clear_cnt_i) begin
            pass_cnt_d = '0;
        end else if (cal_active_i) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
        end
    end

    always_comb begin
        error_d = error_q;
        if (clear_err_i) begin
            error_d = 1'b0;
        end else if (expire_o) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            error_q    <= error_d;
        end
    end

    assign error_o = error_q;

endmodule

// File: rtl/partial_sum_controller.sv
// Sequences the partial-sum datapath one decided bit at a time:
// NEW_BIT_STORE -> (READ -> CAL_AND_STORE)* until the datapath reports finish.
module partial_sum_controller
    import polar_pkg::*;
#(
    parameter int                     STATE_WIDTH      = PS_STATE_WIDTH,
    parameter logic [STATE_WIDTH-1:0] PS_IDLE_CODE     = STATE_WIDTH'(PS_IDLE),
    parameter logic [STATE_WIDTH-1:0] PS_NEW_BIT_CODE  = STATE_WIDTH'(PS_NEW_BIT),
    parameter logic [STATE_WIDTH-1:0] PS_READ_CODE     = STATE_WIDTH'(PS_READ),
    parameter logic [STATE_WIDTH-1:0] PS_CAL_CODE      = STATE_WIDTH'(PS_CAL),
    parameter int                     ID_COUNTER_WIDTH = polar_pkg::ID_COUNTER_WIDTH,
    parameter int                     MAX_CAL_PASSES   = PS_MAX_CAL_PASSES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start_i,
    input  logic                        bit_valid_i,
    input  logic                        bit_data_i,
    output logic                        bit_ready_o,
    output logic [STATE_WIDTH-1:0]      state_o,
    output logic                        new_bit_data_o,
    output logic [ID_COUNTER_WIDTH-1:0] id_counter_value_o,
    input  logic                        cal_fin_i,
    output logic                        ps_done_o,
    output logic                        frame_done_o,
    output logic                        error_o
);

    localparam logic [ID_COUNTER_WIDTH-1:0] LAST_ID = '1;

    ps_ctrl_state_t fsm_q, fsm_d;

    logic                        new_bit_q, new_bit_d;
    logic [ID_COUNTER_WIDTH-1:0] id_q, id_d;
    logic                        ps_done_q, ps_done_d;
    logic                        frame_done_q, frame_done_d;
    logic                        frame_active_q, frame_active_d;

    logic accept;
    logic start_ok;
    logic last_bit;
    logic cal_active;
    logic expire;
    logic error;

    // A frame_start in the same cycle as an offered bit takes priority.
    assign start_ok   = frame_start_i && (fsm_q == S_IDLE);
    assign accept     = bit_valid_i && bit_ready_o && !frame_start_i;
    assign last_bit   = (id_q == LAST_ID);
    assign cal_active = (fsm_q == S_CAL);

    ps_pass_watchdog #(
        .MAX_PASSES (MAX_CAL_PASSES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .clear_cnt_i  (accept),
        .cal_active_i (cal_active),
        .cal_fin_i    (cal_fin_i),
        .clear_err_i  (start_ok),
        .expire_o     (expire),
        .error_o      (error)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    fsm_d = S_NEW;
                end
            end
            // The last bit of a frame feeds no later bit, so no partial sums.
            S_NEW:  fsm_d = last_bit ? S_DONE : S_READ;
            S_READ: fsm_d = S_CAL;
            S_CAL: begin
                if (cal_fin_i) begin
                    fsm_d = S_DONE;
                end else if (expire) begin
                    fsm_d = S_IDLE;
                end else begin
                    fsm_d = S_READ;
                end
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        state_o     = PS_IDLE_CODE;
        bit_ready_o = (fsm_q == S_IDLE) && frame_active_q && !error;
        case (fsm_q)
            S_NEW:   state_o = PS_NEW_BIT_CODE;
            S_READ:  state_o = PS_READ_CODE;
            S_CAL:   state_o = PS_CAL_CODE;
            default: state_o = PS_IDLE_CODE;
        endcase
    end

    always_comb begin
        new_bit_d      = accept ? bit_data_i : new_bit_q;
        id_d           = id_q;
        frame_active_d = frame_active_q;
        if (start_ok) begin
            id_d           = '0;
            frame_active_d = 1'b1;
        end else if (fsm_q == S_DONE) begin
            id_d = id_q + 1'b1;
            if (last_bit) begin
                frame_active_d = 1'b0;
            end
        end else if (expire) begin
            frame_active_d = 1'b0;
        end
        // Completion pulses are registered so they line up with the S_DONE cycle.
        ps_done_d    = (fsm_d == S_DONE);
        frame_done_d = (fsm_d == S_DONE) && last_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_bit_q      <= 1'b0;
            id_q           <= '0;
            ps_done_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            new_bit_q      <= new_bit_d;
            id_q           <= id_d;
            ps_done_q      <= ps_done_d;
            frame_done_q   <= frame_done_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign new_bit_data_o     = new_bit_q;
    assign id_counter_value_o = id_q;
    assign ps_done_o          = ps_done_q;
    assign frame_done_o       = frame_done_q;
    assign error_o            = error;

endmodule
